// File: rtl/data_memory_pkg.sv
// Shared constants and word type for the RV64 doubleword data memory.
package data_memory_pkg;
  localparam int DMEM_DEPTH      = 32;
  localparam int DMEM_DATA_W     = 64;
  localparam int DMEM_ADDR_W     = 64;
  localparam int DMEM_WORD_BYTES = 8;

  typedef logic [DMEM_DATA_W-1:0] word_t;
endpackage

// File: rtl/data_memory_addr_check.sv
// Address decode for the data memory: word index plus a validity flag
// (8-byte aligned and inside the populated byte range).
module dmem_addr_check
  import data_memory_pkg::*;
#(
  parameter int ADDR_WIDTH = DMEM_ADDR_W,
  parameter int DEPTH      = DMEM_DEPTH,
  parameter int IDX_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic [ADDR_WIDTH-1:0] i_address,
  output logic                  o_valid,
  output logic [IDX_W-1:0]      o_idx
);
  localparam logic [ADDR_WIDTH-1:0] BYTE_LIMIT = ADDR_WIDTH'(DEPTH * DMEM_WORD_BYTES);

  logic w_aligned;
  logic w_in_range;

  assign w_aligned  = (i_address[2:0] == 3'b000);
  // Full-width compare so addresses above the range never alias onto real words.
  assign w_in_range = (i_address < BYTE_LIMIT);
  assign o_valid    = w_aligned && w_in_range;
  assign o_idx      = i_address[IDX_W+2:3];
endmodule

// File: rtl/data_memory.sv
// Doubleword data memory for the RV64 MEM stage: synchronous write, combinational
// gated read. Define DMEM_ERR_FLAG_EN to add the access_err output.
module data_memory
  import data_memory_pkg::*;
#(
  parameter int DEPTH      = DMEM_DEPTH,
  parameter int DATA_WIDTH = DMEM_DATA_W,
  parameter int ADDR_WIDTH = DMEM_ADDR_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] writeData,
  input  logic                  MemWrite,
  input  logic                  MemRead,
  output logic [DATA_WIDTH-1:0] readData
`ifdef DMEM_ERR_FLAG_EN
  ,
  output logic                  access_err
`endif
);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic                  w_valid;
  logic [IDX_W-1:0]      w_idx;

  dmem_addr_check #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (DEPTH),
    .IDX_W      (IDX_W)
  ) u_addr_check (
    .i_address (address),
    .o_valid   (w_valid),
    .o_idx     (w_idx)
  );

  // Reset loads each word with its own index and wins over a concurrent store.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= DATA_WIDTH'(unsigned'(i));
      end
    end else if (MemWrite && w_valid) begin
      r_mem[w_idx] <= writeData;
    end
  end

  assign readData = (MemRead && w_valid) ? r_mem[w_idx] : '0;

`ifdef DMEM_ERR_FLAG_EN
  assign access_err = (MemRead || MemWrite) && !w_valid;
`endif
endmodule

// File: tb/tb_data_memory.sv
// Self-checking bench for data_memory: reference word array, expected-value
// queue filled at drive time and drained when readData is sampled.
module tb_data_memory;
  import data_memory_pkg::*;

  logic        clk;
  logic        reset;
  logic [63:0] address;
  word_t       writeData;
  logic        MemWrite;
  logic        MemRead;
  word_t       readData;
`ifdef DMEM_ERR_FLAG_EN
  logic        access_err;
`endif

  data_memory dut (
    .clk       (clk),
    .reset     (reset),
    .address   (address),
    .writeData (writeData),
    .MemWrite  (MemWrite),
    .MemRead   (MemRead),
    .readData  (readData)
`ifdef DMEM_ERR_FLAG_EN
    ,
    .access_err(access_err)
`endif
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  logic [63:0] exp_q[$];
  word_t       model_mem [DMEM_DEPTH];
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
    end
  endtask

  function automatic logic addr_ok(input logic [63:0] a);
    return (a[2:0] == 3'b000) && (a < 64'(DMEM_DEPTH * DMEM_WORD_BYTES));
  endfunction

  function automatic word_t model_read(input logic [63:0] a, input logic rd);
    if (rd && addr_ok(a)) return model_mem[a[7:3]];
    return '0;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < DMEM_DEPTH; i++) model_mem[i] = word_t'(i);
  endtask

  task automatic write_word(input logic [63:0] a, input word_t d);
    address   = a;
    writeData = d;
    MemWrite  = 1'b1;
    MemRead   = 1'b0;
    @(posedge clk); #1;
    MemWrite  = 1'b0;
    if (addr_ok(a)) model_mem[a[7:3]] = d;
  endtask

  task automatic read_word(input string tag, input logic [63:0] a, input logic rd);
    address  = a;
    MemRead  = rd;
    MemWrite = 1'b0;
    exp_q.push_back(model_read(a, rd));
    #2;
    check_eq(tag, readData, exp_q.pop_front());
  endtask

  task automatic dump(input string tag);
    for (int i = 0; i < DMEM_DEPTH; i++) begin
      read_word($sformatf("%s[%0d]", tag, i), 64'(i * 8), 1'b1);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b0; address = '0; writeData = '0; MemWrite = 1'b0; MemRead = 1'b0;
    do_reset();

    // 1. reset pattern
    dump("reset_dump");

    // 2. zero-latency read and read gating
    read_word("read_0x8", 64'h8, 1'b1);
    read_word("read_gated", 64'h8, 1'b0);

    // 3. aligned store
    write_word(64'h10, 64'hDEADBEEFCAFEBABE);
    read_word("read_0x10", 64'h10, 1'b1);
    check_eq("store_value", readData, 64'hDEADBEEFCAFEBABE);
`ifdef DMEM_ERR_FLAG_EN
    check_eq("err_valid", {63'd0, access_err}, 64'd0);
`endif
    dump("store_dump");

    // 4. misaligned access
    read_word("read_0x4", 64'h4, 1'b1);
`ifdef DMEM_ERR_FLAG_EN
    check_eq("err_misaligned", {63'd0, access_err}, 64'd1);
`endif
    write_word(64'h4, 64'h1234);
    dump("misalign_dump");

    // 5. out of range, no aliasing
    read_word("read_0x100", 64'h100, 1'b1);
`ifdef DMEM_ERR_FLAG_EN
    check_eq("err_range", {63'd0, access_err}, 64'd1);
`endif
    write_word(64'h100, 64'h1111);
    write_word(64'h108, 64'h2222);
    write_word(64'h1_0000_0008, 64'h3333);
    read_word("alias_mem1", 64'h8, 1'b1);
    dump("range_dump");

    // read during write: old word before the edge, new word after
    address = 64'h20; writeData = 64'hA5A5_0000_5A5A_FFFF; MemWrite = 1'b1; MemRead = 1'b1;
    exp_q.push_back(model_mem[4]);
    #2;
    check_eq("rdw_old", readData, exp_q.pop_front());
    @(posedge clk); #1;
    MemWrite = 1'b0;
    model_mem[4] = 64'hA5A5_0000_5A5A_FFFF;
    exp_q.push_back(model_mem[4]);
    #1;
    check_eq("rdw_new", readData, exp_q.pop_front());

    // 6. reset beats a same-edge store
    write_word(64'h18, 64'hAAAA);
    read_word("pre_reset_0x18", 64'h18, 1'b1);
    address = 64'h18; writeData = 64'h5555; MemWrite = 1'b1; MemRead = 1'b0;
    do_reset();
    MemWrite = 1'b0;
    read_word("reset_vs_write", 64'h18, 1'b1);
    dump("post_reset_dump");

    // random mix of valid, misaligned and out-of-range traffic
    for (int n = 0; n < 60; n++) begin
      logic [63:0] a;
      case ($urandom_range(0, 3))
        0, 1: a = 64'($urandom_range(0, DMEM_DEPTH - 1) * 8);
        2:    a = 64'($urandom_range(0, 255)) | 64'h1;
        default: a = 64'($urandom_range(32, 100) * 8);
      endcase
      if ($urandom_range(0, 1) == 1)
        write_word(a, {$urandom, $urandom});
      else
        read_word("rand_read", a, 1'($urandom_range(0, 1)));
    end
    dump("final_dump");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
